// File: rtl/sdram_port_arbiter.sv
// SDRAM port arbiter: picks one of PORTS requesters per transaction, using
// fixed priority, round-robin or weighted round-robin selection. It holds the
// grant until the command scheduler reports done. A per-port wait counter
// detects starvation and overrides the policy, locked sequences and credits.
module sdram_port_arbiter #(
  parameter int unsigned PORTS       = 4,
  parameter int unsigned CTRL_PORT   = 0,
  parameter int unsigned MODE        = 1,
  parameter int unsigned WEIGHT_SIZE = 4,
  parameter int unsigned TIMEOUT_CNT = 256
) (
  input  logic                                        clk_i,
  input  logic                                        rst_i,
  input  logic [PORTS-1:0]                            req_i,
  input  logic [PORTS-1:0]                            lock_i,
  input  logic [PORTS*WEIGHT_SIZE-1:0]                weight_i,
  input  logic                                        done_i,
  output logic [PORTS-1:0]                            gnt_o,
  output logic [((PORTS > 1) ? $clog2(PORTS) : 1)-1:0] gnt_id_o,
  output logic                                        gnt_vld_o,
  output logic [PORTS-1:0]                            starve_o
);

  localparam int unsigned IDW = (PORTS > 1) ? $clog2(PORTS) : 1;
  localparam int unsigned CW  = $clog2(TIMEOUT_CNT);
  localparam logic [CW-1:0] SAT = CW'(TIMEOUT_CNT - 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t                 state_q, state_d;
  logic [PORTS-1:0]       gnt_q, gnt_d;
  logic [IDW-1:0]         id_q, id_d;
  logic                   vld_q, vld_d;
  logic [IDW-1:0]         ptr_q, ptr_d;
  logic [WEIGHT_SIZE-1:0] credit_q [PORTS];
  logic [WEIGHT_SIZE-1:0] credit_d [PORTS];
  logic [CW-1:0]          wait_q   [PORTS];
  logic [CW-1:0]          wait_d   [PORTS];

  logic [PORTS-1:0]       starving;
  logic [IDW-1:0]         win_id;
  logic [WEIGHT_SIZE-1:0] win_weight;
  logic [WEIGHT_SIZE-1:0] cred_dec;
  logic                   keep;

  // First set bit of v, scanning upward from index start with wrap-around.
  function automatic logic [IDW-1:0] pick(input logic [PORTS-1:0] v,
                                          input int unsigned start);
    logic [IDW-1:0] res;
    logic           found;
    res   = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < PORTS; i++) begin
      int unsigned idx;
      idx = (start + i) % PORTS;
      if (!found && v[idx]) begin
        found = 1'b1;
        res   = IDW'(idx);
      end
    end
    return res;
  endfunction

  // Wait counters and starvation flags.
  always_comb begin
    for (int unsigned n = 0; n < PORTS; n++) begin
      wait_d[n]   = '0;
      starve_o[n] = (wait_q[n] == SAT);
      if (req_i[n] && !gnt_q[n])
        wait_d[n] = (wait_q[n] == SAT) ? wait_q[n] : wait_q[n] + 1'b1;
    end
    starving = req_i & starve_o;
  end

  // Winner selection: starvation first, then the configured policy.
  always_comb begin
    win_id = '0;
    if (|starving)
      win_id = pick(starving, 0);
    else if (MODE == 0)
      win_id = req_i[CTRL_PORT] ? IDW'(CTRL_PORT) : pick(req_i, 0);
    else
      win_id = pick(req_i, int'(ptr_q) + 1);
    win_weight = weight_i[int'(win_id)*WEIGHT_SIZE +: WEIGHT_SIZE];
  end

  // Next-state logic for the grant FSM, pointer and credits.
  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    id_d     = id_q;
    vld_d    = vld_q;
    ptr_d    = ptr_q;
    credit_d = credit_q;
    cred_dec = '0;
    keep     = 1'b0;
    case (state_q)
      IDLE: begin
        if (|req_i) begin
          state_d        = BUSY;
          gnt_d          = '0;
          gnt_d[win_id]  = 1'b1;
          id_d           = win_id;
          vld_d          = 1'b1;
          ptr_d          = win_id;
          if (MODE == 2)
            credit_d[win_id] = (win_weight == '0) ? WEIGHT_SIZE'(1) : win_weight;
        end
      end
      BUSY: begin
        if (done_i) begin
          cred_dec = (credit_q[id_q] == '0) ? '0 : credit_q[id_q] - 1'b1;
          if (MODE == 2)
            credit_d[id_q] = cred_dec;
          // A starving requester vetoes both lock and credit retention.
          keep = !(|starving) && req_i[id_q] &&
                 (lock_i[id_q] || ((MODE == 2) && (cred_dec != '0)));
          if (!keep) begin
            state_d = IDLE;
            gnt_d   = '0;
            vld_d   = 1'b0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      id_q    <= '0;
      vld_q   <= 1'b0;
      ptr_q   <= IDW'(PORTS - 1);
      for (int unsigned n = 0; n < PORTS; n++) begin
        credit_q[n] <= '0;
        wait_q[n]   <= '0;
      end
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      id_q     <= id_d;
      vld_q    <= vld_d;
      ptr_q    <= ptr_d;
      credit_q <= credit_d;
      wait_q   <= wait_d;
    end
  end

  assign gnt_o     = gnt_q;
  assign gnt_id_o  = id_q;
  assign gnt_vld_o = vld_q;

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Self-checking bench for sdram_port_arbiter: four configurations share one
// stimulus bus; each vector names the instance whose outputs it checks.
module tb_sdram_port_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req = '0;
  logic [3:0]  lock = '0;
  logic        done = 1'b0;
  logic [15:0] weight = 16'h0013;  // port0=3, port1=1, ports 2/3=0

  always #5 clk = ~clk;

  logic [3:0] gnt_rr, gnt_fp, gnt_wrr, st_rr, st_fp, st_wrr;
  logic [1:0] id_rr, id_fp, id_wrr;
  logic       vld_rr, vld_fp, vld_wrr;
  logic [0:0] gnt_one, id_one, st_one;
  logic       vld_one;

  sdram_port_arbiter #(.PORTS(4), .MODE(1)) u_rr (
    .clk_i(clk), .rst_i(rst), .req_i(req), .lock_i(lock), .weight_i(weight),
    .done_i(done), .gnt_o(gnt_rr), .gnt_id_o(id_rr), .gnt_vld_o(vld_rr),
    .starve_o(st_rr));

  sdram_port_arbiter #(.PORTS(4), .CTRL_PORT(2), .MODE(0), .TIMEOUT_CNT(8)) u_fp (
    .clk_i(clk), .rst_i(rst), .req_i(req), .lock_i(lock), .weight_i(weight),
    .done_i(done), .gnt_o(gnt_fp), .gnt_id_o(id_fp), .gnt_vld_o(vld_fp),
    .starve_o(st_fp));

  sdram_port_arbiter #(.PORTS(4), .MODE(2)) u_wrr (
    .clk_i(clk), .rst_i(rst), .req_i(req), .lock_i(lock), .weight_i(weight),
    .done_i(done), .gnt_o(gnt_wrr), .gnt_id_o(id_wrr), .gnt_vld_o(vld_wrr),
    .starve_o(st_wrr));

  sdram_port_arbiter #(.PORTS(1), .MODE(1)) u_one (
    .clk_i(clk), .rst_i(rst), .req_i(req[0:0]), .lock_i(lock[0:0]),
    .weight_i(weight[3:0]), .done_i(done), .gnt_o(gnt_one), .gnt_id_o(id_one),
    .gnt_vld_o(vld_one), .starve_o(st_one));

  typedef struct {
    int         sel;
    logic       rst;
    logic [3:0] req;
    logic [3:0] lock;
    logic       done;
    logic [3:0] gnt;
    logic [3:0] starve;
    string      name;
  } vec_t;

  typedef struct {
    int         sel;
    logic       vld;
    logic [3:0] gnt;
    logic [3:0] starve;
    string      name;
  } exp_t;

  vec_t vecs[$];
  exp_t exp_q[$];
  int   total = 0;
  int   bad = 0;

  function automatic void add(input int sel, input logic r, input logic [3:0] rq,
                              input logic [3:0] lk, input logic d,
                              input logic [3:0] g, input logic [3:0] s,
                              input string nm);
    vec_t v;
    v.sel = sel; v.rst = r; v.req = rq; v.lock = lk; v.done = d;
    v.gnt = g; v.starve = s; v.name = nm;
    vecs.push_back(v);
  endfunction

  function automatic int idx_of(input logic [3:0] g);
    int r;
    r = 0;
    for (int i = 0; i < 4; i++) if (g[i]) r = i;
    return r;
  endfunction

  task automatic check(input exp_t e);
    logic [3:0] ag, ast;
    logic       av;
    int         aid, eid;
    case (e.sel)
      0:       begin ag = gnt_rr;  av = vld_rr;  aid = int'(id_rr);  ast = st_rr;  end
      1:       begin ag = gnt_fp;  av = vld_fp;  aid = int'(id_fp);  ast = st_fp;  end
      2:       begin ag = gnt_wrr; av = vld_wrr; aid = int'(id_wrr); ast = st_wrr; end
      default: begin ag = {3'b000, gnt_one}; av = vld_one; aid = int'(id_one);
                     ast = {3'b000, st_one}; end
    endcase
    eid = idx_of(e.gnt);
    total++;
    if (av !== e.vld || ag !== e.gnt || ast !== e.starve || (e.vld && aid != eid)) begin
      bad++;
      $display("FAIL %s: got gnt=%b vld=%b id=%0d starve=%b, want gnt=%b vld=%b id=%0d starve=%b",
               e.name, ag, av, aid, ast, e.gnt, e.vld, eid, e.starve);
    end
  endtask

  task automatic run_vec(input vec_t v);
    exp_t e;
    rst = v.rst; req = v.req; lock = v.lock; done = v.done;
    e.sel = v.sel; e.gnt = v.gnt; e.vld = |v.gnt; e.starve = v.starve; e.name = v.name;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      total++; bad++;
      $display("FAIL scoreboard_empty: got 0 entries, want 1");
    end else begin
      check(exp_q.pop_front());
    end
  endtask

  initial begin
    // Round-robin order 0,1,2,3,0 with done each busy cycle; hold; idle done.
    add(0,1,4'h0,4'h0,0,4'b0000,4'h0,"rr_reset");
    add(0,0,4'hF,4'h0,0,4'b0001,4'h0,"rr_g0");
    add(0,0,4'hF,4'h0,1,4'b0000,4'h0,"rr_d0");
    add(0,0,4'hF,4'h0,0,4'b0010,4'h0,"rr_g1");
    add(0,0,4'hF,4'h0,1,4'b0000,4'h0,"rr_d1");
    add(0,0,4'hF,4'h0,0,4'b0100,4'h0,"rr_g2");
    add(0,0,4'hF,4'h0,1,4'b0000,4'h0,"rr_d2");
    add(0,0,4'hF,4'h0,0,4'b1000,4'h0,"rr_g3");
    add(0,0,4'hF,4'h0,1,4'b0000,4'h0,"rr_d3");
    add(0,0,4'hF,4'h0,0,4'b0001,4'h0,"rr_wrap0");
    add(0,0,4'b0010,4'h0,0,4'b0001,4'h0,"rr_hold_req_change");
    add(0,0,4'h0,4'h0,1,4'b0000,4'h0,"rr_release");
    add(0,0,4'h0,4'h0,1,4'b0000,4'h0,"rr_idle_done");
    add(0,0,4'b0100,4'h0,1,4'b0100,4'h0,"rr_done_ignored_idle");
    add(0,0,4'b0100,4'h0,1,4'b0000,4'h0,"rr_end");
    // Fixed priority, CTRL_PORT=2: port 0 held, then port 2 before port 1.
    add(1,1,4'h0,4'h0,0,4'b0000,4'h0,"fp_reset");
    add(1,0,4'b0001,4'h0,0,4'b0001,4'h0,"fp_g0");
    add(1,0,4'b0111,4'h0,0,4'b0001,4'h0,"fp_hold_a");
    add(1,0,4'b0111,4'h0,0,4'b0001,4'h0,"fp_hold_b");
    add(1,0,4'b0111,4'h0,1,4'b0000,4'h0,"fp_d0");
    add(1,0,4'b0111,4'h0,0,4'b0100,4'h0,"fp_ctrl_wins");
    add(1,0,4'b0111,4'h0,1,4'b0000,4'h0,"fp_d2");
    add(1,0,4'b0101,4'h0,0,4'b0100,4'h0,"fp_ctrl_over_0");
    add(1,0,4'b0101,4'h0,1,4'b0000,4'h0,"fp_d2b");
    add(1,0,4'b0001,4'h0,0,4'b0001,4'h0,"fp_lowest");
    add(1,0,4'b0000,4'h0,1,4'b0000,4'h0,"fp_end");
    // Weighted round-robin: port0 weight 3, port1 weight 1, port2 weight 0.
    add(2,1,4'h0,4'h0,0,4'b0000,4'h0,"wrr_reset");
    add(2,0,4'b0011,4'h0,0,4'b0001,4'h0,"wrr_g0");
    add(2,0,4'b0011,4'h0,1,4'b0001,4'h0,"wrr_keep1");
    add(2,0,4'b0011,4'h0,1,4'b0001,4'h0,"wrr_keep2");
    add(2,0,4'b0011,4'h0,1,4'b0000,4'h0,"wrr_credit_out");
    add(2,0,4'b0011,4'h0,0,4'b0010,4'h0,"wrr_g1");
    add(2,0,4'b0011,4'h0,1,4'b0000,4'h0,"wrr_d1");
    add(2,0,4'b0011,4'h0,0,4'b0001,4'h0,"wrr_g0_again");
    add(2,0,4'b0100,4'h0,1,4'b0000,4'h0,"wrr_req_drop");
    add(2,0,4'b0100,4'h0,0,4'b0100,4'h0,"wrr_g2");
    add(2,0,4'b0100,4'h0,1,4'b0000,4'h0,"wrr_w0_as_1");
    // Lock on port 1 broken by port 3 starving (TIMEOUT_CNT=8).
    add(1,1,4'h0,4'h0,0,4'b0000,4'h0,"st_reset");
    add(1,0,4'b0010,4'b0010,0,4'b0010,4'h0,"st_g1");
    add(1,0,4'b1010,4'b0010,0,4'b0010,4'h0,"st_wait1");
    add(1,0,4'b1010,4'b0010,1,4'b0010,4'h0,"st_lock_keep");
    add(1,0,4'b1010,4'b0010,0,4'b0010,4'h0,"st_wait3");
    add(1,0,4'b1010,4'b0010,0,4'b0010,4'h0,"st_wait4");
    add(1,0,4'b1010,4'b0010,0,4'b0010,4'h0,"st_wait5");
    add(1,0,4'b1010,4'b0010,0,4'b0010,4'h0,"st_wait6");
    add(1,0,4'b1010,4'b0010,0,4'b0010,4'b1000,"st_starve_rise");
    add(1,0,4'b1010,4'b0010,1,4'b0000,4'b1000,"st_lock_broken");
    add(1,0,4'b1010,4'b0010,0,4'b1000,4'b1000,"st_g3");
    add(1,0,4'b1010,4'b0010,0,4'b1000,4'b0000,"st_cleared");
    // Single-port configuration.
    add(3,1,4'h0,4'h0,0,4'b0000,4'h0,"one_reset");
    add(3,0,4'b0001,4'h0,0,4'b0001,4'h0,"one_g0");
    add(3,0,4'b0001,4'h0,1,4'b0000,4'h0,"one_d0");
    add(3,0,4'b0001,4'h0,0,4'b0001,4'h0,"one_g0_again");
    add(3,0,4'b0000,4'h0,1,4'b0000,4'h0,"one_end");

    foreach (vecs[i]) run_vec(vecs[i]);

    // Reset asserted while busy drops the grant without a clock edge.
    begin
      vec_t v;
      v.sel = 0; v.rst = 1; v.req = 4'h0; v.lock = 4'h0; v.done = 0;
      v.gnt = 4'b0000; v.starve = 4'h0; v.name = "arst_pre";
      run_vec(v);
      v.rst = 0; v.req = 4'b0001; v.gnt = 4'b0001; v.name = "arst_busy";
      run_vec(v);
      rst = 1'b1;
      #1;
      total++;
      if (gnt_rr !== 4'b0000 || vld_rr !== 1'b0) begin
        bad++;
        $display("FAIL arst_same_cycle: got gnt=%b vld=%b, want gnt=0000 vld=0", gnt_rr, vld_rr);
      end
      v.rst = 1; v.req = 4'b0010; v.gnt = 4'b0000; v.name = "arst_held";
      run_vec(v);
      v.rst = 0; v.req = 4'b0010; v.gnt = 4'b0010; v.name = "arst_first_grant";
      run_vec(v);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
